// File: rtl/instr_mem_loader.sv
// Program loader and 16-bit fetch port for the core's byte-wide instruction RAM.
// Optional macro LOADER_CHECKSUM_EN adds a trailing two's-complement checksum byte.
module instr_mem_loader #(
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     core_hold,
  output logic                     load_done,
  output logic                     loaded,
  output logic                     load_err,
  input  logic [ADDRESS_WIDTH-1:0] fetch_addr,
  output logic [15:0]              fetch_data,
  output logic [1:0]               dbg_state
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

`ifdef LOADER_CHECKSUM_EN
  localparam logic [1:0] ST_AFTER_DATA = ST_CHECK;
`else
  localparam logic [1:0] ST_AFTER_DATA = ST_DONE;
`endif

  logic [1:0]               state_q;
  logic [1:0]               state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q;
  logic [ADDRESS_WIDTH-1:0] fetch_addr_hi;
  logic [7:0]               mem [DEPTH];
  logic                     xfer;

  // Handshake: a byte moves on any rising edge where in_valid and in_ready are
  // both high; in_ready is high only in LOAD/CHECK and never depends on in_valid.
  assign in_ready      = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign xfer          = in_valid && in_ready;
  assign load_done     = (state_q == ST_DONE);
  assign dbg_state     = state_q;
  assign fetch_addr_hi = fetch_addr + ADDR_ONE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  if (xfer && (cnt_q == LAST_ADDR)) state_d = ST_AFTER_DATA;
      ST_CHECK: if (xfer) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      core_hold  <= 1'b0;
      loaded     <= 1'b0;
      fetch_data <= 16'h0000;
    end else begin
      state_q    <= state_d;
      core_hold  <= (state_d == ST_LOAD) || (state_d == ST_CHECK);
      if ((state_q == ST_IDLE) && start)
        cnt_q <= '0;
      else if ((state_q == ST_LOAD) && xfer)
        cnt_q <= cnt_q + ADDR_ONE;
      if (state_q == ST_DONE)
        loaded <= 1'b1;
      fetch_data <= {mem[fetch_addr_hi], mem[fetch_addr]};
    end
  end

  // Contents survive reset so a core reset does not require a reload.
  always_ff @(posedge clk) begin
    if (rst && (state_q == ST_LOAD) && xfer)
      mem[cnt_q] <= in_data;
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       load_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_q      <= 8'h00;
      load_err_q <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && start)
        sum_q <= 8'h00;
      else if ((state_q == ST_LOAD) && xfer)
        sum_q <= sum_q + in_data;
      // A good checksum byte brings the running sum back to zero.
      if ((state_q == ST_CHECK) && xfer)
        load_err_q <= ((sum_q + in_data) != 8'h00);
    end
  end

  assign load_err = load_err_q;
`else
  assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: loads, backpressure, ignored inputs,
// reset mid-load, read-before-write and (with LOADER_CHECKSUM_EN) checksum handling.
module tb_instr_mem_loader;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
`ifdef LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          core_hold;
  logic          load_done;
  logic          loaded;
  logic          load_err;
  logic [AW-1:0] fetch_addr;
  logic [15:0]   fetch_data;
  logic [1:0]    dbg_state;

  instr_mem_loader #(.ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .core_hold(core_hold), .load_done(load_done),
    .loaded(loaded), .load_err(load_err), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int hold_cnt = 0;
  int done_cnt = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  model   [DEPTH];
  logic        model_v [DEPTH];
  logic [7:0]  prog    [DEPTH];

  always @(negedge clk) begin
    if (core_hold === 1'b1) hold_cnt++;
    if (load_done === 1'b1) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic fetch_all(input string tag);
    logic [AW-1:0] a;
    logic [AW-1:0] a1;
    for (int i = 0; i < DEPTH; i++) begin
      a  = AW'(i);
      a1 = a + AW'(1);
      fetch_addr = a;
      exp_q.push_back({model[a1], model[a]});
      tick();
      check(tag, fetch_data, exp_q.pop_front());
    end
  endtask

  // Presents one data byte while fetching the address being written, so the
  // fetch must return the pre-write contents.
  task automatic push_byte(input logic [7:0] b, input int idx, input logic pulse_start);
    int            guard;
    logic          do_cmp;
    logic [AW-1:0] a;
    logic [AW-1:0] a1;
    guard    = 0;
    a        = AW'(idx);
    a1       = a + AW'(1);
    in_data  = b;
    in_valid = 1'b1;
    start    = pulse_start;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("ready_wait", (guard < 20), 1);
    fetch_addr = a;
    do_cmp = model_v[a] && model_v[a1];
    if (do_cmp) exp_q.push_back({model[a1], model[a]});
    tick();
    in_valid = 1'b0;
    start    = 1'b0;
    if (do_cmp) check("rbw_fetch", fetch_data, exp_q.pop_front());
    model[a]   = b;
    model_v[a] = 1'b1;
  endtask

  task automatic run_load(input int gap, input int mid_start, input logic [7:0] ck_adj,
                          input logic exp_err);
    int         h0;
    int         d0;
    logic [7:0] sum;
    h0  = hold_cnt;
    d0  = done_cnt;
    sum = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("hold_rise", core_hold, 1);
    for (int i = 0; i < DEPTH; i++) begin
      if (gap != 0) begin
        in_valid = 1'b0;
        tick();
      end
      push_byte(prog[i], i, (i == mid_start));
      sum = sum + prog[i];
    end
    if (CK != 0) begin
      check("check_state", dbg_state, S_CHECK);
      in_data  = (~sum + 8'h01) + ck_adj;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
    end
    check("done_pulse", load_done, 1);
    check("hold_fall", core_hold, 0);
    check("ready_done", in_ready, 0);
    check("load_err", load_err, exp_err);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("idle_after_done", dbg_state, S_IDLE);
    check("loaded", loaded, 1);
    check("hold_cycles", hold_cnt - h0, DEPTH * (1 + gap) + CK);
    check("done_count", done_cnt - d0, 1);
    check("load_err_held", load_err, exp_err);
  endtask

  task automatic set_prog_ramp();
    for (int i = 0; i < DEPTH; i++) prog[i] = 8'h10 + 8'(i);
  endtask

  task automatic set_prog_rand();
    for (int i = 0; i < DEPTH; i++) prog[i] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model[i]   = 8'h00;
      model_v[i] = 1'b0;
    end
    rst        = 1'b0;
    start      = 1'b0;
    in_data    = 8'h00;
    in_valid   = 1'b0;
    fetch_addr = '0;

    repeat (2) tick();
    check("rst_fetch_data", fetch_data, 16'h0000);
    check("rst_state", dbg_state, S_IDLE);
    rst = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_core_hold", core_hold, 0);
    check("rst_loaded", loaded, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_err", load_err, 0);

    // Basic contiguous load, then full readback (addr 0 -> 16'h1110).
    set_prog_ramp();
    run_load(0, -1, 8'h00, 1'b0);
    fetch_all("fetch_basic");

    // Random contents so the next ramp load has something to overwrite.
    set_prog_rand();
    run_load(0, -1, 8'h00, 1'b0);
    fetch_all("fetch_rand");

    // Backpressure: in_valid low every other cycle; addr 7 wraps to 16'h1017.
    set_prog_ramp();
    run_load(1, -1, 8'h00, 1'b0);
    fetch_all("fetch_bp");

    // Bytes offered in IDLE are neither accepted nor written.
    in_data  = 8'hEE;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_in_ready", in_ready, 0);
      check("idle_state", dbg_state, S_IDLE);
    end
    in_valid = 1'b0;
    fetch_all("fetch_idle_noop");

    // start pulsed mid-load must not restart the counter.
    set_prog_rand();
    run_load(0, 3, 8'h00, 1'b0);
    fetch_all("fetch_midstart");

    // Reset after 3 of 8 bytes.
    set_prog_rand();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(prog[i], i, 1'b0);
    rst = 1'b0;
    tick();
    check("mid_rst_state", dbg_state, S_IDLE);
    check("mid_rst_hold", core_hold, 0);
    check("mid_rst_loaded", loaded, 0);
    rst = 1'b1;
    tick();
    check("post_rst_ready", in_ready, 0);
    check("post_rst_loaded", loaded, 0);
    fetch_all("fetch_partial");

    if (CK != 0) begin
      // Ramp sums to 0x9C: wrong byte 0x65 flags, correct byte 0x64 clears.
      set_prog_ramp();
      run_load(0, -1, 8'h01, 1'b1);
      fetch_all("fetch_ck_bad");
      run_load(0, -1, 8'h00, 1'b0);
      fetch_all("fetch_ck_good");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
